// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Multiplexed seven-segment display driver. Hex-decodes a DIGITS-nibble
//   value and scans it across DIGITS one-hot select lines. Each digit slot is
//   PRESCALE cycles long, and its first DEADTIME cycles are forced dark.
//   Loads go into a pending buffer. The pending buffer is copied into the
//   active buffer only at a frame boundary, so a frame never shows a mix of
//   old and new digits. Optional leading-zero blanking is applied to the
//   active buffer.
//
//   Optional feature macro: SEG_BRIGHTNESS_EN. When it is defined, the block
//   adds the i_brightness[3:0] port and a 4-bit PWM counter that gates the
//   segments and dp during the lit part of each slot.
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   i_ena          scan enable; low = dark display, scan position cleared
//   i_value_in     hex value, nibble i drives digit i (nibble 0 = LSD)
//   i_dp_in        decimal point per digit
//   i_load         capture i_value_in / i_dp_in into the pending buffer
//   i_blank_lead   suppress leading zeros
//   i_brightness   PWM duty 0..15 (SEG_BRIGHTNESS_EN only)
//   o_segments     {g,f,e,d,c,b,a}, active-high
//   o_dp           decimal point, active-high
//   o_digit_sel    one-hot digit enable, active-high
//   o_frame_done   one-cycle pulse during the last cycle of the last slot
module seg_scan_driver #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 1000,
   parameter int DEADTIME = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_ena,
   input  logic [4*DIGITS-1:0]   i_value_in,
   input  logic [DIGITS-1:0]     i_dp_in,
   input  logic                  i_load,
   input  logic                  i_blank_lead,
`ifdef SEG_BRIGHTNESS_EN
   input  logic [3:0]            i_brightness,
`endif
   output logic [6:0]            o_segments,
   output logic                  o_dp,
   output logic [DIGITS-1:0]     o_digit_sel,
   output logic                  o_frame_done
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] C_DEAD = CW'(DEADTIME);
   localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic [IW-1:0]         r_idx;
   logic [4*DIGITS-1:0]   r_pend_val, r_act_val;
   logic [DIGITS-1:0]     r_pend_dp,  r_act_dp;

   state_t                w_state_nx;
   logic [CW-1:0]         w_cnt_nx;
   logic [IW-1:0]         w_idx_nx;
   logic                  w_commit;
   logic [4*DIGITS-1:0]   w_pend_val_nx, w_act_val_nx;
   logic [DIGITS-1:0]     w_pend_dp_nx,  w_act_dp_nx;
   logic [DIGITS-1:0]     w_zero_above;   // bit i: nibbles i..DIGITS-1 all zero
   logic                  w_zacc;
   logic [3:0]            w_nib;
   logic                  w_lit, w_blank, w_duty;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   // Next scan position and buffer contents. The outputs are registered from
   // these next values, so what the pins show lines up with the counter
   // value of the same cycle.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_idx_nx   = r_idx;
      w_commit   = 1'b0;
      if (!i_ena) begin
         w_state_nx = IDLE;
         w_cnt_nx   = '0;
         w_idx_nx   = '0;
      end else if (r_state == IDLE) begin
         w_state_nx = SCAN;
         w_cnt_nx   = '0;
         w_idx_nx   = '0;
         w_commit   = 1'b1;
      end else if (r_cnt == C_LAST) begin
         w_cnt_nx = '0;
         if (r_idx == I_LAST) begin
            w_idx_nx = '0;
            w_commit = 1'b1;
         end else begin
            w_idx_nx = r_idx + 1'b1;
         end
      end else begin
         w_cnt_nx = r_cnt + 1'b1;
      end

      // A load in the same cycle as a commit goes straight into the active buffer.
      w_pend_val_nx = i_load ? i_value_in : r_pend_val;
      w_pend_dp_nx  = i_load ? i_dp_in    : r_pend_dp;
      w_act_val_nx  = w_commit ? w_pend_val_nx : r_act_val;
      w_act_dp_nx   = w_commit ? w_pend_dp_nx  : r_act_dp;

      w_zacc       = 1'b1;
      w_zero_above = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_zacc          = w_zacc & (w_act_val_nx[4*i +: 4] == 4'h0);
         w_zero_above[i] = w_zacc;
      end

      w_nib   = w_act_val_nx[{w_idx_nx, 2'b00} +: 4];
      w_lit   = (w_state_nx == SCAN) && (w_cnt_nx >= C_DEAD);
      w_blank = i_blank_lead && (w_idx_nx != '0) && w_zero_above[w_idx_nx];
   end

`ifdef SEG_BRIGHTNESS_EN
   logic [3:0] r_pwm;
   logic [3:0] w_pwm_nx;
   always_comb begin
      w_pwm_nx = (w_state_nx == SCAN) ? r_pwm + 4'd1 : r_pwm;
      w_duty   = (i_brightness == 4'hF) || (w_pwm_nx < i_brightness);
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) r_pwm <= 4'd0;
      else       r_pwm <= w_pwm_nx;
   end
`else
   assign w_duty = 1'b1;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_pend_val   <= '0;
         r_pend_dp    <= '0;
         r_act_val    <= '0;
         r_act_dp     <= '0;
         o_segments   <= '0;
         o_dp         <= 1'b0;
         o_digit_sel  <= '0;
         o_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_cnt        <= w_cnt_nx;
         r_idx        <= w_idx_nx;
         r_pend_val   <= w_pend_val_nx;
         r_pend_dp    <= w_pend_dp_nx;
         r_act_val    <= w_act_val_nx;
         r_act_dp     <= w_act_dp_nx;
         o_digit_sel  <= w_lit ? (DIGITS'(1) << w_idx_nx) : '0;
         o_segments   <= (w_lit && w_duty && !w_blank) ? hex7(w_nib) : 7'h00;
         o_dp         <= w_lit && w_duty && w_act_dp_nx[w_idx_nx];
         o_frame_done <= (w_state_nx == SCAN) && (w_cnt_nx == C_LAST) && (w_idx_nx == I_LAST);
      end
   end

endmodule
